cnf_assign_enum: RTL and testbench

- Sequential stimulus/collection stage placed directly upstream of a flat combinational clause network (AND of 2-input ORs, multiple outputs).
- Enumerates every assignment of NUM_VARS variables onto the network inputs and waits SETTLE cycles for the outputs.
- Samples the NUM_OUTS output vector and compares it to a target mask.
- Reports SAT/UNSAT, the first matching assignment and the total number of matches. Used for exhaustive checking of small benchmarks.

---
 rtl/cnf_pkg.sv | 25 ++
 rtl/cnf_settle_cnt.sv | 27 ++
 rtl/cnf_assign_enum.sv | 178 +++++++++++++++++
 tb/tb_cnf_assign_enum.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/cnf_pkg.sv
// Shared types and helpers for the exhaustive CNF assignment enumerator.
// Operands narrower than CNF_MAX_OUTS must be zero-extended by the caller.
package cnf_pkg;

    localparam int CNF_MAX_VARS = 24;
    localparam int CNF_MAX_OUTS = 32;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DRIVE  = 3'd1,
        ST_WAIT   = 3'd2,
        ST_SAMPLE = 3'd3,
        ST_DONE   = 3'd4
    } cnf_enum_state_t;

    // Bits outside care never block a match, so zero-extension of all three operands is safe.
    function automatic logic cnf_match(
        input logic [CNF_MAX_OUTS-1:0] out,
        input logic [CNF_MAX_OUTS-1:0] target,
        input logic [CNF_MAX_OUTS-1:0] care
    );
        return (((out ~^ target) & care) == care);
    endfunction

endpackage

// File: rtl/cnf_settle_cnt.sv
// 3-bit settle down-counter: load, decrement-to-zero, zero flag.
module cnf_settle_cnt (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_load,
    input  logic [2:0] i_load_val,
    input  logic       i_dec,
    output logic [2:0] o_cnt,
    output logic       o_zero
);

    logic [2:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= 3'd0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_dec && (r_cnt != 3'd0)) begin
            r_cnt <= r_cnt - 3'd1;
        end
    end

    assign o_cnt  = r_cnt;
    assign o_zero = (r_cnt == 3'd0);

endmodule

// File: rtl/cnf_assign_enum.sv
// Drives every NUM_VARS-bit assignment into an external clause network and
// collects SAT, first witness and match count from its sampled outputs.
//
// state  | meaning
// IDLE   | waiting for start
// DRIVE  | net_in just updated, network settling begins
// WAIT   | SETTLE-cycle settle window counted by cnf_settle_cnt
// SAMPLE | compare net_out with latched target/care, advance or finish
// DONE   | results held until start, abort or reset
module cnf_assign_enum
    import cnf_pkg::*;
#(
    parameter  int NUM_VARS = 8,
    parameter  int NUM_OUTS = 6,
    parameter  int SETTLE   = 1,
    localparam int CNT_W    = NUM_VARS + 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                abort,
    input  logic [NUM_OUTS-1:0] target,
    input  logic [NUM_OUTS-1:0] care,
    input  logic                stop_first,
    output logic [NUM_VARS-1:0] net_in,
    input  logic [NUM_OUTS-1:0] net_out,
    output logic                busy,
    output logic                done,
    output logic                sat,
    output logic [NUM_VARS-1:0] witness,
    output logic [CNT_W-1:0]    match_cnt
);

    cnf_enum_state_t r_state;
    cnf_enum_state_t w_state_nxt;

    logic [NUM_VARS-1:0] r_net_in;
    logic [NUM_VARS-1:0] r_witness;
    logic [CNT_W-1:0]    r_match_cnt;
    logic                r_sat;
    logic [NUM_OUTS-1:0] r_target;
    logic [NUM_OUTS-1:0] r_care;
    logic                r_stop_first;

    logic                    w_begin;
    logic                    w_clear;
    logic                    w_sample;
    logic                    w_cnt_load;
    logic                    w_cnt_dec;
    logic [2:0]              w_cnt;
    logic                    w_cnt_zero;
    logic                    w_match;
    logic                    w_last;
    logic [CNF_MAX_OUTS-1:0] w_out_ext;
    logic [CNF_MAX_OUTS-1:0] w_target_ext;
    logic [CNF_MAX_OUTS-1:0] w_care_ext;

    assign w_out_ext    = CNF_MAX_OUTS'(net_out);
    assign w_target_ext = CNF_MAX_OUTS'(r_target);
    assign w_care_ext   = CNF_MAX_OUTS'(r_care);
    assign w_match      = cnf_match(w_out_ext, w_target_ext, w_care_ext);
    assign w_last       = &r_net_in;

    cnf_settle_cnt u_settle (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_cnt_load),
        .i_load_val (3'(SETTLE)),
        .i_dec      (w_cnt_dec),
        .o_cnt      (w_cnt),
        .o_zero     (w_cnt_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_begin     = 1'b0;
        w_clear     = 1'b0;
        w_sample    = 1'b0;
        w_cnt_load  = 1'b0;
        w_cnt_dec   = 1'b0;
        if (abort) begin
            w_state_nxt = ST_IDLE;
            w_clear     = 1'b1;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        w_state_nxt = ST_DRIVE;
                        w_begin     = 1'b1;
                    end
                end
                ST_DRIVE: begin
                    if (SETTLE == 0) begin
                        w_state_nxt = ST_SAMPLE;
                    end else begin
                        w_state_nxt = ST_WAIT;
                        w_cnt_load  = 1'b1;
                    end
                end
                ST_WAIT: begin
                    w_cnt_dec = 1'b1;
                    // Zero check keeps the FSM from sticking if the counter is ever found empty.
                    if ((w_cnt == 3'd1) || w_cnt_zero) begin
                        w_state_nxt = ST_SAMPLE;
                    end
                end
                ST_SAMPLE: begin
                    w_sample = 1'b1;
                    if ((w_match && r_stop_first) || w_last) begin
                        w_state_nxt = ST_DONE;
                    end else begin
                        w_state_nxt = ST_DRIVE;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_net_in     <= '0;
            r_witness    <= '0;
            r_match_cnt  <= '0;
            r_sat        <= 1'b0;
            r_target     <= '0;
            r_care       <= '0;
            r_stop_first <= 1'b0;
        end else if (w_clear) begin
            // Abort drops results and latched config but leaves net_in where it was.
            r_witness    <= '0;
            r_match_cnt  <= '0;
            r_sat        <= 1'b0;
            r_target     <= '0;
            r_care       <= '0;
            r_stop_first <= 1'b0;
        end else if (w_begin) begin
            r_net_in     <= '0;
            r_witness    <= '0;
            r_match_cnt  <= '0;
            r_sat        <= 1'b0;
            r_target     <= target;
            r_care       <= care;
            r_stop_first <= stop_first;
        end else if (w_sample) begin
            if (w_match) begin
                if (r_match_cnt != {CNT_W{1'b1}}) begin
                    r_match_cnt <= r_match_cnt + 1'b1;
                end
                if (!r_sat) begin
                    r_witness <= r_net_in;
                    r_sat     <= 1'b1;
                end
            end
            if (!((w_match && r_stop_first) || w_last)) begin
                r_net_in <= r_net_in + 1'b1;
            end
        end
    end

    assign net_in    = r_net_in;
    assign witness   = r_witness;
    assign match_cnt = r_match_cnt;
    assign sat       = r_sat;
    assign busy      = (r_state == ST_DRIVE) || (r_state == ST_WAIT) || (r_state == ST_SAMPLE);
    assign done      = (r_state == ST_DONE);

endmodule

// File: tb/tb_cnf_assign_enum.sv
// Bench for cnf_assign_enum: directed runs plus random CNF networks, checked
// against an enumeration model that evaluates the network arithmetically.
module tb_cnf_assign_enum;

    localparam int NV = 4;
    localparam int NO = 6;
    localparam int ST = 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [NO-1:0] target = '0;
    logic [NO-1:0] care = '0;
    logic          stop_first = 1'b0;
    logic [NV-1:0] net_in;
    logic [NO-1:0] net_out;
    logic          busy;
    logic          done;
    logic          sat;
    logic [NV-1:0] witness;
    logic [NV:0]   match_cnt;

    int errors = 0;
    int checks = 0;
    int mode   = 0;
    int lv [NO][2][2];
    bit ln [NO][2][2];
    logic t_o;

    cnf_assign_enum #(.NUM_VARS(NV), .NUM_OUTS(NO), .SETTLE(ST)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .abort      (abort),
        .target     (target),
        .care       (care),
        .stop_first (stop_first),
        .net_in     (net_in),
        .net_out    (net_out),
        .busy       (busy),
        .done       (done),
        .sat        (sat),
        .witness    (witness),
        .match_cnt  (match_cnt)
    );

    always #5 clk = ~clk;

    // External clause network (AND of 2-input ORs), selected by mode.
    always_comb begin
        net_out = '0;
        t_o     = 1'b0;
        case (mode)
            0: net_out[0] = (net_in[0] | net_in[1]) & (net_in[2] | net_in[3]);
            1: net_out[0] = net_in[0] & ~net_in[0];
            2: begin
                net_out[1] = net_in[0] & net_in[1];
                net_out[0] = net_in[0] | net_in[1];
            end
            default: begin
                for (int k = 0; k < NO; k++) begin
                    t_o = 1'b1;
                    for (int c = 0; c < 2; c++) begin
                        t_o = t_o & ((net_in[lv[k][c][0]] ^ ln[k][c][0]) |
                                     (net_in[lv[k][c][1]] ^ ln[k][c][1]));
                    end
                    net_out[k] = t_o;
                end
            end
        endcase
    end

    function automatic int xb(input int a, input int i);
        return (a >> i) & 1;
    endfunction

    function automatic int ref_out(input int a);
        int o;
        int r;
        r = 0;
        case (mode)
            0: r = (xb(a,0) | xb(a,1)) & (xb(a,2) | xb(a,3));
            1: r = xb(a,0) & (1 - xb(a,0));
            2: r = ((xb(a,0) & xb(a,1)) << 1) | (xb(a,0) | xb(a,1));
            default: begin
                for (int k = 0; k < NO; k++) begin
                    o = 1;
                    for (int c = 0; c < 2; c++)
                        o = o & ((xb(a, lv[k][c][0]) ^ int'(ln[k][c][0])) |
                                 (xb(a, lv[k][c][1]) ^ int'(ln[k][c][1])));
                    r = r | (o << k);
                end
            end
        endcase
        return r;
    endfunction

    task automatic model(input bit sf, input int tg, input int cr,
                         output int e_sat, output int e_wit, output int e_cnt,
                         output int e_last, output int e_cyc);
        int o;
        e_sat = 0; e_wit = 0; e_cnt = 0; e_last = (1 << NV) - 1;
        for (int a = 0; a < (1 << NV); a++) begin
            o = ref_out(a);
            if (((~(o ^ tg)) & cr) == cr) begin
                e_cnt++;
                if (e_sat == 0) begin
                    e_sat = 1;
                    e_wit = a;
                end
                if (sf) begin
                    e_last = a;
                    break;
                end
            end
        end
        e_cyc = (e_last + 1) * (ST + 2) + 1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic run(input string tag, input bit sf, input logic [NO-1:0] tg,
                       input logic [NO-1:0] cr, input bit poke);
        int e_sat, e_wit, e_cnt, e_last, e_cyc, n;
        logic busy_seen;
        model(sf, int'(tg), int'(cr), e_sat, e_wit, e_cnt, e_last, e_cyc);
        @(posedge clk); #1;
        target = tg; care = cr; stop_first = sf; start = 1'b1;
        n = 0;
        busy_seen = 1'b0;
        do begin
            @(posedge clk); #1;
            n++;
            if (n == 1) begin
                start = 1'b0;
                busy_seen = busy;
                target = ~tg; care = ~cr; stop_first = ~sf;
            end
            if (poke && n == 5) start = 1'b1;
            if (poke && n == 6) start = 1'b0;
        end while (!done && n < 200);
        chk({tag, ".busy"},    32'(busy_seen), 32'd1);
        chk({tag, ".cycles"},  32'(n),         32'(e_cyc));
        chk({tag, ".sat"},     32'(sat),       32'(e_sat));
        chk({tag, ".witness"}, 32'(witness),   32'(e_wit));
        chk({tag, ".count"},   32'(match_cnt), 32'(e_cnt));
        chk({tag, ".net_in"},  32'(net_in),    32'(e_last));
        @(posedge clk); #1;
        chk({tag, ".hold"},    {30'd0, done, busy}, 32'd2);
        chk({tag, ".holdcnt"}, 32'(match_cnt), 32'(e_cnt));
    endtask

    initial begin
        #2 rst_n = 1'b0;
        #1;
        chk("reset.outs", {net_in, witness, match_cnt, sat, busy, done}, 32'd0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;

        mode = 0;
        run("s1_full", 1'b0, 6'd1, 6'd1, 1'b0);
        run("s2_first", 1'b1, 6'd1, 6'd1, 1'b0);
        mode = 1;
        run("s3_unsat", 1'b0, 6'd1, 6'd1, 1'b0);
        mode = 2;
        run("s4_two_out", 1'b0, 6'b000001, 6'b000011, 1'b0);
        run("care_zero", 1'b0, 6'd1, 6'd0, 1'b0);

        // start and abort together: abort wins, net_in holds at last value.
        @(posedge clk); #1;
        start = 1'b1; abort = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0;
        chk("both.flags", {30'd0, done, busy}, 32'd0);
        chk("both.res",   {sat, witness, match_cnt}, 32'd0);
        chk("both.net_in", 32'(net_in), 32'hF);

        // abort in the middle of scenario 1
        mode = 0;
        @(posedge clk); #1;
        target = 6'd1; care = 6'd1; stop_first = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        chk("abort.flags", {30'd0, done, busy}, 32'd0);
        chk("abort.res",   {sat, witness, match_cnt}, 32'd0);
        chk("abort.net_in", 32'(net_in), 32'((10 - 1) / (ST + 2)));
        run("s5_rerun_poke", 1'b0, 6'd1, 6'd1, 1'b1);

        // asynchronous reset between clock edges in the middle of a run
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (19) @(posedge clk);
        #1;
        chk("pre_rst.net_in", 32'(net_in), 32'((20 - 1) / (ST + 2)));
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid.outs", {net_in, witness, match_cnt, sat, busy, done}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run("s6_after_rst", 1'b0, 6'd1, 6'd1, 1'b0);

        mode = 3;
        for (int r = 0; r < 8; r++) begin
            for (int k = 0; k < NO; k++)
                for (int c = 0; c < 2; c++)
                    for (int j = 0; j < 2; j++) begin
                        lv[k][c][j] = int'($urandom_range(0, NV - 1));
                        ln[k][c][j] = 1'($urandom);
                    end
            run($sformatf("rand%0d", r), 1'($urandom), 6'($urandom),
                6'($urandom & $urandom), 1'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
